// File: rtl/generation_engine_if.sv
// Command, frame-buffer write and status signals shared by the addressing engine,
// the rectangle-fill generation engine and frame-buffer memory.
interface generation_engine_if;
  logic        gen_start_strobe;
  logic [15:0] init_addr;
  logic [15:0] cmd_data_origx;
  logic [15:0] cmd_data_width;
  logic [15:0] cmd_data_height;
  logic [2:0]  cmd_data_color;
  logic [15:0] mem_addr;
  logic [23:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_we;
  logic        mem_ready;
  logic        gen_busy;
  logic        gen_done;

  // Command source and memory side: drives the command and the write acknowledge.
  modport master (
    output gen_start_strobe, init_addr, cmd_data_origx, cmd_data_width,
           cmd_data_height, cmd_data_color, mem_ready,
    input  mem_addr, mem_wdata, mem_wmask, mem_we, gen_busy, gen_done
  );

  // Generation engine side.
  modport slave (
    input  gen_start_strobe, init_addr, cmd_data_origx, cmd_data_width,
           cmd_data_height, cmd_data_color, mem_ready,
    output mem_addr, mem_wdata, mem_wmask, mem_we, gen_busy, gen_done
  );
endinterface

// File: rtl/generation_engine.sv
// Rectangle fill: turns a latched fill command into masked 24-bit word writes
// (8 pixels x 3 bits per word), row by row, with a we/ready handshake.
module generation_engine #(
  parameter int SCREEN_WIDTH = 640
) (
  input  logic               clk,
  input  logic               rst_,
  generation_engine_if.slave bus
);
  localparam logic [15:0] ROW_BYTES = 16'(SCREEN_WIDTH / 8 * 3);

  typedef enum logic [2:0] {IDLE, SETUP, WRITE, ROW_NEXT, DONE} state_t;

  state_t      state_q;
  logic [15:0] initAddr_q, width_q, height_q;
  logic [2:0]  origx_q, color_q;
  logic [15:0] rowBase_q, colAddr_q, pxLeft_q, rowsLeft_q;
  logic [2:0]  offset_q;
  logic [15:0] memAddr_q;
  logic [23:0] memWdata_q;
  logic [7:0]  memWmask_q;
  logic        memWe_q, busy_q, done_q;

  logic [3:0]  curSpan;
  logic [15:0] pxLeft_d, colAddr_d, rowBase_d;
  logic [7:0]  nextMask_d, firstMask_d;
  logic        unusedOrigxHi;

  // Pixels covered by a word starting at pixel 'off' with 'left' pixels still to paint.
  function automatic logic [3:0] spanOf(input logic [2:0] off, input logic [15:0] left);
    logic [3:0] room;
    room = 4'd8 - {1'b0, off};
    if (left >= {12'd0, room}) return room;
    return left[3:0];
  endfunction

  function automatic logic [7:0] maskOf(input logic [2:0] off, input logic [3:0] span);
    logic [7:0] ones;
    ones = span[3] ? 8'hFF : ((8'd1 << span[2:0]) - 8'd1);
    return ones << off;
  endfunction

  always_comb begin
    curSpan     = spanOf(offset_q, pxLeft_q);
    pxLeft_d    = pxLeft_q - {12'd0, curSpan};
    colAddr_d   = colAddr_q + 16'd3;
    rowBase_d   = rowBase_q + ROW_BYTES;
    nextMask_d  = maskOf(3'd0, spanOf(3'd0, pxLeft_d));
    firstMask_d = maskOf(origx_q, spanOf(origx_q, width_q));
  end

  assign unusedOrigxHi = |bus.cmd_data_origx[15:3];

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= IDLE;
      initAddr_q <= '0;
      width_q    <= '0;
      height_q   <= '0;
      origx_q    <= '0;
      color_q    <= '0;
      rowBase_q  <= '0;
      colAddr_q  <= '0;
      pxLeft_q   <= '0;
      rowsLeft_q <= '0;
      offset_q   <= '0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      memWmask_q <= '0;
      memWe_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.gen_start_strobe) begin
            initAddr_q <= bus.init_addr;
            origx_q    <= bus.cmd_data_origx[2:0];
            width_q    <= bus.cmd_data_width;
            height_q   <= bus.cmd_data_height;
            color_q    <= bus.cmd_data_color;
            busy_q     <= 1'b1;
            state_q    <= SETUP;
          end
        end
        SETUP: begin
          if (width_q == 16'd0 || height_q == 16'd0) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            rowBase_q  <= initAddr_q;
            colAddr_q  <= initAddr_q;
            pxLeft_q   <= width_q;
            offset_q   <= origx_q;
            rowsLeft_q <= height_q;
            memAddr_q  <= initAddr_q;
            memWmask_q <= firstMask_d;
            memWdata_q <= {8{color_q}};
            memWe_q    <= 1'b1;
            state_q    <= WRITE;
          end
        end
        WRITE: begin
          // Nothing moves until memory takes the presented word.
          if (memWe_q && bus.mem_ready) begin
            pxLeft_q  <= pxLeft_d;
            offset_q  <= 3'd0;
            colAddr_q <= colAddr_d;
            if (pxLeft_d == 16'd0) begin
              memWe_q <= 1'b0;
              state_q <= ROW_NEXT;
            end else begin
              memAddr_q  <= colAddr_d;
              memWmask_q <= nextMask_d;
            end
          end
        end
        ROW_NEXT: begin
          rowsLeft_q <= rowsLeft_q - 16'd1;
          if (rowsLeft_q == 16'd1) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            rowBase_q  <= rowBase_d;
            colAddr_q  <= rowBase_d;
            pxLeft_q   <= width_q;
            offset_q   <= origx_q;
            memAddr_q  <= rowBase_d;
            memWmask_q <= firstMask_d;
            memWe_q    <= 1'b1;
            state_q    <= WRITE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_wdata = memWdata_q;
  assign bus.mem_wmask = memWmask_q;
  assign bus.mem_we    = memWe_q;
  assign bus.gen_busy  = busy_q;
  assign bus.gen_done  = done_q;
endmodule

// File: doc/generation_engine.md
Name: generation_engine

Overview:
Rectangle-fill stage directly downstream of the addressing engine. Takes the packed frame-buffer start address (`init_addr`) plus the command geometry and colour, and issues masked 24-bit word writes to frame-buffer memory. The frame buffer is 3 bits per pixel, 8 pixels per 24-bit word (3 bytes). Each row is filled left to right, then the block steps to the next row.

Parameters:
- SCREEN_WIDTH, 640, pixels per display row; must be a multiple of 8.
- ROW_BYTES, SCREEN_WIDTH/8*3 (240), byte stride between rows.

Ports:
- clk  in  1  system clock
- rst_  in  1  asynchronous active-low reset
- gen_start_strobe  in  1  start pulse from the addressing engine
- init_addr  in  16  byte address of the word holding the top-left pixel
- cmd_data_origx  in  16  origin x; only [2:0] is used (pixel offset within the first word)
- cmd_data_width  in  16  rectangle width in pixels
- cmd_data_height  in  16  rectangle height in rows
- cmd_data_color  in  3  fill colour
- mem_addr  out  16  write byte address (multiple of 3)
- mem_wdata  out  24  write data
- mem_wmask  out  8  per-pixel write enable; bit i covers pixel i
- mem_we  out  1  write request
- mem_ready  in  1  memory accepts the current write
- gen_busy  out  1  command in progress
- gen_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, `rst_` low):
  - state=IDLE.
  - `mem_addr`, `mem_wdata`, `mem_wmask`, `mem_we`, `gen_busy`, `gen_done` all 0.
  - Reset mid-command abandons any pending write immediately; no partial state survives.
- Pixel packing:
  - Pixel i of a word occupies `wdata[3i+2:3i]`.
  - `mem_wdata` = `cmd_data_color` replicated 8 times (e.g. colour 5 gives 24'hB6DB6D).
- Command start:
  - Accepted only in IDLE on a clock where `gen_start_strobe`=1.
  - Latches `init_addr`, `origx[2:0]`, width, height and colour; all of these may change afterwards without effect.
  - A strobe while not IDLE is ignored.
- States:
  - IDLE -> SETUP on an accepted strobe.
  - SETUP:
    - If width==0 or height==0, go to DONE.
    - Otherwise: row_base=latched addr, col_addr=row_base, px_left=width, offset=origx[2:0], rows_left=height; go to WRITE.
  - WRITE:
    - `mem_we`=1, `mem_addr`=col_addr.
    - `mem_wmask` bits are set for pixels offset .. min(7, offset+px_left-1).
    - A transfer completes on a clock with `mem_we`&`mem_ready`.
    - On completion: px_left -= (number of set mask bits), offset=0, col_addr += 3.
    - If px_left becomes 0, go to ROW_NEXT with `mem_we` dropped to 0.
    - Otherwise stay in WRITE and present the next word on the following cycle (back-to-back at 1 word/clk when `mem_ready` is held high).
  - ROW_NEXT:
    - rows_left -= 1.
    - If rows_left becomes 0, go to DONE.
    - Otherwise: row_base += ROW_BYTES, col_addr=new row_base, px_left=width, offset=latched origx[2:0]; go to WRITE.
  - DONE: `gen_done`=1 for exactly one cycle, then IDLE.
- Handshake:
  - While `mem_we`=1 and `mem_ready`=0, `mem_addr`, `mem_wdata` and `mem_wmask` hold stable and no counter advances.
  - `mem_we` never deasserts before acceptance.
- Timing:
  - `gen_busy`=1 in every state except IDLE (SETUP through DONE inclusive).
  - First `mem_we` is high 2 cycles after the strobe clock.
  - With `mem_ready`=1 throughout, total cycles from strobe to `gen_done` = 2 + total words + rows.
- Arithmetic:
  - All address arithmetic is modulo 2^16 (wrap silently).
  - No horizontal clipping: a row that runs past the screen edge continues into the following words.
  - Width and height counters are 16-bit unsigned.

Test Plan:
1. `init_addr`=0, origx=0, width=8, height=1, colour=5, `mem_ready`=1 -> one write: addr 0, mask 8'hFF, wdata 24'hB6DB6D. `mem_we` high 2 cycles after the strobe; `gen_done` pulses once; `gen_busy` low afterwards.
2. `init_addr`=0, origx=5, width=6, height=2, colour=3 -> writes in order: (0, 8'hE0), (3, 8'h07), (240, 8'hE0), (243, 8'h07); then a single `gen_done`.
3. Same as scenario 1 but `mem_ready` held low for 3 cycles after `mem_we` rises -> addr/data/mask stable for 4 cycles; exactly one write accepted; `gen_done` delayed by 3 cycles.
4. width=0 (height=4) and, separately, height=0 -> no `mem_we` ever asserted; `gen_done` pulses 2 cycles after the strobe.
5. Second `gen_start_strobe` with different `init_addr` mid-command -> ignored; all writes use the first command's values. A strobe after `gen_done` is accepted normally.
6. Assert `rst_` low mid-row while `mem_we`=1 -> all outputs 0 immediately. After release, a new command (scenario 1 values) produces exactly the scenario-1 write.
